// File: rtl/matmul_job_sched.sv
// rtl/matmul_job_sched.sv - two-requester round-robin matmul job scheduler with done/timeout handling
package types;
    localparam int LEN = 16;
endpackage

module matmul_job_sched #(
    parameter int LEN            = types::LEN,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*LEN-1:0] req_src1,
    input  logic [2*LEN-1:0] req_src2,
    input  logic [2*LEN-1:0] req_dst,
    input  logic             mem_done,
    output logic             start,
    output logic [LEN-1:0]   src1_addr,
    output logic [LEN-1:0]   src2_addr,
    output logic [LEN-1:0]   dst_addr,
    output logic             cmp_valid,
    output logic             cmp_id,
    output logic             cmp_err
);

    // One counter serves both the RUN timeout and the GAP length.
    localparam int MAXC  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rr;
    logic [CNT_W-1:0] cnt;
    logic             gnt_id;
    logic             hs;
    logic             run_fin;
    logic             gap_last;
    logic [LEN-1:0]   sel_src1;
    logic [LEN-1:0]   sel_src2;
    logic [LEN-1:0]   sel_dst;

    // A lone requester wins outright; rr only breaks ties.
    always_comb begin
        case (req_valid)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = rr;
            default: gnt_id = 1'b0;
        endcase
        req_ready = 2'b00;
        if (state == IDLE && rst_n && (|req_valid))
            req_ready = gnt_id ? 2'b10 : 2'b01;
    end

    assign hs       = |(req_valid & req_ready);
    assign run_fin  = (state == RUN) && (mem_done || cnt == TMO_LAST);
    assign gap_last = (state == GAP) && (cnt == GAP_LAST);

    assign sel_src1 = gnt_id ? req_src1[2*LEN-1:LEN] : req_src1[LEN-1:0];
    assign sel_src2 = gnt_id ? req_src2[2*LEN-1:LEN] : req_src2[LEN-1:0];
    assign sel_dst  = gnt_id ? req_dst[2*LEN-1:LEN]  : req_dst[LEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs)       state_nxt = RUN;
            RUN:     if (run_fin)  state_nxt = GAP;
            GAP:     if (gap_last) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rr        <= 1'b0;
            start     <= 1'b0;
            src1_addr <= '0;
            src2_addr <= '0;
            dst_addr  <= '0;
            cmp_valid <= 1'b0;
            cmp_id    <= 1'b0;
            cmp_err   <= 1'b0;
        end else begin
            cmp_valid <= 1'b0;
            if (hs || run_fin || gap_last)
                cnt <= '0;
            else if (state != IDLE)
                cnt <= cnt + 1'b1;
            if (hs) begin
                src1_addr <= sel_src1;
                src2_addr <= sel_src2;
                dst_addr  <= sel_dst;
                cmp_id    <= gnt_id;
                rr        <= ~gnt_id;
                start     <= 1'b1;
            end
            // mem_done on the final timeout cycle still counts as success.
            if (run_fin) begin
                start     <= 1'b0;
                cmp_valid <= 1'b1;
                cmp_err   <= ~mem_done;
            end
        end
    end

endmodule

// File: tb/tb_matmul_job_sched.sv
// tb/tb_matmul_job_sched.sv - directed table-driven bench for matmul_job_sched
module tb_matmul_job_sched;

    localparam int LEN = types::LEN;
    localparam int GAP = 4;
    localparam int TMO = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2*LEN-1:0] req_src1, req_src2, req_dst;
    logic             mem_done;
    logic             start;
    logic [LEN-1:0]   src1_addr, src2_addr, dst_addr;
    logic             cmp_valid, cmp_id, cmp_err;

    int checks = 0;
    int errors = 0;

    matmul_job_sched #(.LEN(LEN), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
        .mem_done(mem_done), .start(start), .src1_addr(src1_addr),
        .src2_addr(src2_addr), .dst_addr(dst_addr), .cmp_valid(cmp_valid),
        .cmp_id(cmp_id), .cmp_err(cmp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     valid;
        logic [LEN-1:0] s1_0, s2_0, d_0, s1_1, s2_1, d_1;
        int             done_at;
        logic           exp_id;
        int             exp_high;
        logic           exp_err;
        int             exp_wait;
    } job_t;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] exp_ready;
    } gnt_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic job_t mk(input logic [1:0] v, input int a0, input int b0, input int c0,
                                input int a1, input int b1, input int c1, input int done,
                                input logic id, input int high, input logic err, input int w);
        job_t j;
        j.valid = v;
        j.s1_0 = LEN'(a0); j.s2_0 = LEN'(b0); j.d_0 = LEN'(c0);
        j.s1_1 = LEN'(a1); j.s2_1 = LEN'(b1); j.d_1 = LEN'(c1);
        j.done_at = done; j.exp_id = id; j.exp_high = high; j.exp_err = err; j.exp_wait = w;
        return j;
    endfunction

    // Presents a request, pulses mem_done through any GAP, runs the job and checks completion.
    task automatic run_job(input job_t j);
        logic [LEN-1:0] e1, e2, e3;
        int w, high, guard;
        e1 = j.exp_id ? j.s1_1 : j.s1_0;
        e2 = j.exp_id ? j.s2_1 : j.s2_0;
        e3 = j.exp_id ? j.d_1  : j.d_0;
        req_src1 = {j.s1_1, j.s1_0};
        req_src2 = {j.s2_1, j.s2_0};
        req_dst  = {j.d_1,  j.d_0};
        req_valid = j.valid;
        #1;
        w = 0;
        while (req_ready == 2'b00 && w < 50) begin
            chk("gap_start_low", 32'(start), 0);
            mem_done = 1'b1;
            tick();
            mem_done = 1'b0;
            w++;
            if (w == 1) chk("cmp_single_cycle", 32'(cmp_valid), 0);
        end
        chk("handshake_wait", w, j.exp_wait);
        chk("grant", 32'(req_ready), j.exp_id ? 2 : 1);
        tick();
        req_valid = 2'b00;
        chk("start_rise", 32'(start), 1);
        chk("src1_addr", 32'(src1_addr), 32'(e1));
        chk("src2_addr", 32'(src2_addr), 32'(e2));
        chk("dst_addr", 32'(dst_addr), 32'(e3));
        high = 1;
        guard = 0;
        while (start === 1'b1 && guard < 100) begin
            if (high > 1 && cmp_valid !== 1'b0) chk("cmp_in_run", 32'(cmp_valid), 0);
            mem_done = (high == j.done_at);
            tick();
            mem_done = 1'b0;
            guard++;
            if (start === 1'b1) high++;
        end
        chk("start_high_cycles", high, j.exp_high);
        chk("cmp_valid", 32'(cmp_valid), 1);
        chk("cmp_id", 32'(cmp_id), 32'(j.exp_id));
        chk("cmp_err", 32'(cmp_err), 32'(j.exp_err));
        chk("src1_held", 32'(src1_addr), 32'(e1));
        chk("dst_held", 32'(dst_addr), 32'(e3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t jobs[6];
        gnt_t gnts[4];
        int   w;

        gnts[0] = '{2'b00, 2'b00};
        gnts[1] = '{2'b01, 2'b01};
        gnts[2] = '{2'b10, 2'b10};
        gnts[3] = '{2'b11, 2'b01};

        jobs[0] = mk(2'b01, 100, 200, 300, 0, 0, 0, 10, 1'b0, 10, 1'b0, 0);
        jobs[1] = mk(2'b11, 7, 8, 9, 1, 20, 40, 1, 1'b1, 1, 1'b0, GAP);
        jobs[2] = mk(2'b11, 5, 6, 7, 2, 3, 4, 0, 1'b0, TMO, 1'b1, GAP);
        jobs[3] = mk(2'b01, 11, 12, 13, 0, 0, 0, TMO, 1'b0, TMO, 1'b0, GAP);
        jobs[4] = mk(2'b11, 31, 32, 33, 21, 22, 23, 3, 1'b1, 3, 1'b0, GAP);
        jobs[5] = mk(2'b11, 41, 42, 43, 51, 52, 53, 2, 1'b0, 2, 1'b0, GAP);

        rst_n = 1'b0;
        req_valid = 2'b11;
        req_src1 = {16'd5, 16'd6};
        req_src2 = {16'd7, 16'd8};
        req_dst  = {16'd9, 16'd10};
        mem_done = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_src1", 32'(src1_addr), 0);
        chk("rst_src2", 32'(src2_addr), 0);
        chk("rst_dst", 32'(dst_addr), 0);
        chk("rst_cmp_valid", 32'(cmp_valid), 0);
        chk("rst_cmp_id", 32'(cmp_id), 0);
        chk("rst_cmp_err", 32'(cmp_err), 0);

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = gnts[i].valid;
            #1;
            chk("idle_grant", 32'(req_ready), 32'(gnts[i].exp_ready));
        end
        req_valid = 2'b00;
        tick();

        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("idle_done_cmp", 32'(cmp_valid), 0);
        chk("idle_done_start", 32'(start), 0);
        tick();
        chk("idle_done_cmp2", 32'(cmp_valid), 0);

        for (int i = 0; i < 6; i++) run_job(jobs[i]);

        // rr was left favouring requester 1; reset must bring it back to 0.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        run_job(mk(2'b11, 100, 200, 300, 1, 20, 40, 10, 1'b0, 10, 1'b0, 0));
        run_job(mk(2'b11, 100, 200, 300, 1, 20, 40, 5, 1'b1, 5, 1'b0, GAP));

        // Abort a job with reset five cycles into RUN.
        req_src1 = {16'd60, 16'd61};
        req_src2 = {16'd62, 16'd63};
        req_dst  = {16'd64, 16'd65};
        req_valid = 2'b01;
        #1;
        w = 0;
        while (req_ready == 2'b00 && w < 50) begin
            tick();
            w++;
        end
        chk("abort_wait", w, GAP);
        tick();
        req_valid = 2'b00;
        repeat (4) tick();
        chk("abort_start_before", 32'(start), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_start_async", 32'(start), 0);
        chk("abort_src1", 32'(src1_addr), 0);
        req_valid = 2'b10;
        #1;
        chk("abort_ready_in_rst", 32'(req_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_cmp", 32'(cmp_valid), 0);
            chk("abort_start_low", 32'(start), 0);
        end
        rst_n = 1'b1;
        run_job(mk(2'b10, 0, 0, 0, 9, 8, 7, 2, 1'b1, 2, 1'b0, 0));
        run_job(mk(2'b11, 3, 3, 3, 4, 4, 4, 1, 1'b0, 1, 1'b0, GAP));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
